// File: rtl/sched_cmp_probe_if.sv
// ---------------------------------------------------------------------------
// sched_cmp_probe_if
// Report stream interface of sched_cmp_probe: one word per channel, carrying
// the channel index and its mismatch count, moved by a valid/ready handshake.
//
//   rpt_valid  master->slave  report word valid
//   rpt_ready  slave->master  consumer accepts the current word
//   rpt_chan   master->slave  channel index of the current word
//   rpt_count  master->slave  mismatch count of rpt_chan
//   rpt_last   master->slave  current word belongs to the highest channel
// ---------------------------------------------------------------------------
interface sched_cmp_probe_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             rpt_valid;
  logic             rpt_ready;
  logic [IDX_W-1:0] rpt_chan;
  logic [CNT_W-1:0] rpt_count;
  logic             rpt_last;

  modport master (
    output rpt_valid,
    output rpt_chan,
    output rpt_count,
    output rpt_last,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid,
    input  rpt_chan,
    input  rpt_count,
    input  rpt_last,
    output rpt_ready
  );
endinterface

// File: rtl/sched_cmp_probe.sv
// ---------------------------------------------------------------------------
// sched_cmp_probe
// Clocked equivalence probe. Each of CHANNELS pairs (a_i, b_i) is compared
// with 4-state inequality on the rising clock edge whenever smp_en is high.
// Per-channel saturating mismatch counters are kept, the first mismatch is
// captured, and on request the counters are streamed out (clear-on-read).
//
//   clk         sole clock
//   rst_n       asynchronous active-low reset
//   smp_en      sample enable
//   a, b        packed pairs, channel i at [i*WIDTH +: WIDTH]
//   rpt_req     level request for a report, acted on only when idle
//   rpt         report stream (master side of sched_cmp_probe_if)
//   first_vld   sticky flag: first mismatch captured
//   first_chan  lowest mismatching channel of the capturing cycle
//   first_a/b   values of that channel at capture
//   any_mm      registered OR of the last sampled cycle's mismatches
// ---------------------------------------------------------------------------
module sched_cmp_probe #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      smp_en,
  input  logic [CHANNELS*WIDTH-1:0] a,
  input  logic [CHANNELS*WIDTH-1:0] b,
  input  logic                      rpt_req,
  sched_cmp_probe_if.master         rpt,
  output logic                      first_vld,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] first_chan,
  output logic [WIDTH-1:0]          first_a,
  output logic [WIDTH-1:0]          first_b,
  output logic                      any_mm
);

  localparam int               IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_nxt;

  logic [CNT_W-1:0] cnt [CHANNELS];
  logic [CHANNELS-1:0] mm;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic [WIDTH-1:0] hit_a;
  logic [WIDTH-1:0] hit_b;

  logic             sending;
  logic             accept;
  logic             is_last;

  // 4-state compare: X/Z against a known value is a mismatch, while an
  // identical X pattern on both sides is not.
  always_comb begin
    mm = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      mm[i] = smp_en && (a[i*WIDTH +: WIDTH] !== b[i*WIDTH +: WIDTH]);
    end
  end

  // Lowest-index mismatch wins; scanning downwards leaves the lowest hit.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_a   = '0;
    hit_b   = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (mm[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
        hit_a   = a[i*WIDTH +: WIDTH];
        hit_b   = b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign sending = (state == SEND);
  assign accept  = sending && rpt.rpt_ready;
  assign is_last = (ptr == LAST_IDX);

  // Accepting a word clears its counter, but a mismatch landing on the same
  // edge restarts the count at 1 so no increment is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (accept && (ptr == IDX_W'(i))) begin
          cnt[i] <= mm[i] ? CNT_W'(1) : '0;
        end else if (mm[i] && (cnt[i] != CNT_MAX)) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // First-mismatch capture is sticky until reset; any_mm tracks each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_vld  <= 1'b0;
      first_chan <= '0;
      first_a    <= '0;
      first_b    <= '0;
      any_mm     <= 1'b0;
    end else begin
      any_mm <= |mm;
      if (!first_vld && hit) begin
        first_vld  <= 1'b1;
        first_chan <= hit_idx;
        first_a    <= hit_a;
        first_b    <= hit_b;
      end
    end
  end

  // Report FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // DONE inserts one idle cycle so a held rpt_req cannot start the next
  // report back-to-back with the last word.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (rpt_req) begin
          state_nxt = SEND;
          ptr_nxt   = '0;
        end
      end
      SEND: begin
        if (rpt.rpt_ready) begin
          if (is_last) begin
            state_nxt = DONE;
          end else begin
            ptr_nxt = ptr + IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // rpt_count follows the live counter so increments during backpressure
  // are visible; everything else derives from registered state only.
  always_comb begin
    rpt.rpt_valid = sending;
    rpt.rpt_chan  = sending ? ptr : '0;
    rpt.rpt_count = sending ? cnt[ptr] : '0;
    rpt.rpt_last  = sending && is_last;
  end

endmodule

// File: tb/tb_sched_cmp_probe.sv
// ---------------------------------------------------------------------------
// tb_sched_cmp_probe
// Directed bench for sched_cmp_probe (WIDTH=8, CHANNELS=4, CNT_W=2) with a
// reference model kept as plain integer counters and a report position.
// ---------------------------------------------------------------------------
module tb_sched_cmp_probe;

  localparam int CH   = 4;
  localparam int W    = 8;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          smp_en;
  logic [CH*W-1:0] a_v;
  logic [CH*W-1:0] b_v;
  logic          rpt_req;
  logic          rpt_ready;
  logic          first_vld;
  logic [1:0]    first_chan;
  logic [W-1:0]  first_a;
  logic [W-1:0]  first_b;
  logic          any_mm;

  int checks = 0;
  int errors = 0;

  sched_cmp_probe_if #(.CHANNELS(CH), .CNT_W(CW)) rpt_if ();

  assign rpt_if.rpt_ready = rpt_ready;

  sched_cmp_probe #(
    .WIDTH   (W),
    .CHANNELS(CH),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .smp_en    (smp_en),
    .a         (a_v),
    .b         (b_v),
    .rpt_req   (rpt_req),
    .rpt       (rpt_if),
    .first_vld (first_vld),
    .first_chan(first_chan),
    .first_a   (first_a),
    .first_b   (first_b),
    .any_mm    (any_mm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: counts as integers, report position -1 idle, 0..CH-1 word
  // on offer, CH the gap cycle after the last word.
  int          m_cnt [CH];
  int          rpos;
  bit          m_fv;
  int          m_fc;
  logic [W-1:0] m_fa;
  logic [W-1:0] m_fb;
  bit          m_any;
  bit          mmv [CH];
  bit          acc;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < CH; i++) m_cnt[i] = 0;
    rpos  = -1;
    m_fv  = 1'b0;
    m_fc  = 0;
    m_fa  = '0;
    m_fb  = '0;
    m_any = 1'b0;
  endtask

  task automatic modelStep();
    bit anyv;
    anyv = 1'b0;
    for (int i = 0; i < CH; i++) begin
      mmv[i] = smp_en && (a_v[i*W +: W] !== b_v[i*W +: W]);
      anyv   = anyv | mmv[i];
    end
    acc = (rpos >= 0) && (rpos < CH) && rpt_ready;
    for (int i = 0; i < CH; i++) begin
      if (acc && (rpos == i)) m_cnt[i] = mmv[i] ? 1 : 0;
      else if (mmv[i] && (m_cnt[i] < MAXC)) m_cnt[i] = m_cnt[i] + 1;
    end
    for (int i = 0; i < CH; i++) begin
      if (!m_fv && mmv[i]) begin
        m_fv = 1'b1;
        m_fc = i;
        m_fa = a_v[i*W +: W];
        m_fb = b_v[i*W +: W];
      end
    end
    m_any = anyv;
    if (rpos == -1) begin
      if (rpt_req) rpos = 0;
    end else if (rpos == CH) begin
      rpos = -1;
    end else if (acc) begin
      rpos = rpos + 1;
    end
  endtask

  task automatic modelCompare();
    bit mv;
    mv = (rpos >= 0) && (rpos < CH);
    checkOutput("model_valid", rpt_if.rpt_valid, mv);
    if (mv) begin
      checkOutput("model_chan",  rpt_if.rpt_chan,  rpos);
      checkOutput("model_count", rpt_if.rpt_count, m_cnt[rpos]);
      checkOutput("model_last",  rpt_if.rpt_last,  rpos == CH - 1);
    end
    checkOutput("model_first_vld",  first_vld,  m_fv);
    checkOutput("model_first_chan", first_chan, m_fc);
    checkOutput("model_first_a",    first_a,    m_fa);
    checkOutput("model_first_b",    first_b,    m_fb);
    checkOutput("model_any_mm",     any_mm,     m_any);
  endtask

  // Model advances with the DUT's edges and resets with it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) modelReset();
    else modelStep();
  end

  // Outputs are compared half a cycle away from the sampling edge.
  always @(negedge clk) modelCompare();

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic setChan(input int ch, input logic [W-1:0] av, input logic [W-1:0] bv);
    a_v[ch*W +: W] = av;
    b_v[ch*W +: W] = bv;
  endtask

  task automatic setAllEqual();
    a_v = {CH{8'h5A}};
    b_v = {CH{8'h5A}};
  endtask

  task automatic doReset();
    #2 rst_n = 1'b0;
    #1;
    applyStimulus(1);
    rst_n = 1'b1;
  endtask

  task automatic readReport(input int e0, input int e1, input int e2, input int e3);
    int e [CH];
    e = '{e0, e1, e2, e3};
    rpt_req   = 1'b1;
    rpt_ready = 1'b1;
    applyStimulus(1);
    rpt_req = 1'b0;
    for (int k = 0; k < CH; k++) begin
      checkOutput("rep_valid", rpt_if.rpt_valid, 1);
      checkOutput("rep_chan",  rpt_if.rpt_chan,  k);
      checkOutput("rep_count", rpt_if.rpt_count, e[k]);
      checkOutput("rep_last",  rpt_if.rpt_last,  k == CH - 1);
      applyStimulus(1);
    end
    checkOutput("rep_gap", rpt_if.rpt_valid, 0);
    rpt_ready = 1'b0;
    applyStimulus(1);
  endtask

  initial begin
    rst_n     = 1'b1;
    smp_en    = 1'b0;
    rpt_req   = 1'b0;
    rpt_ready = 1'b0;
    a_v       = '0;
    b_v       = '0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_valid",      rpt_if.rpt_valid, 0);
    checkOutput("rst_chan",       rpt_if.rpt_chan,  0);
    checkOutput("rst_count",      rpt_if.rpt_count, 0);
    checkOutput("rst_last",       rpt_if.rpt_last,  0);
    checkOutput("rst_first_vld",  first_vld,  0);
    checkOutput("rst_first_chan", first_chan, 0);
    checkOutput("rst_first_a",    first_a,    0);
    checkOutput("rst_first_b",    first_b,    0);
    checkOutput("rst_any_mm",     any_mm,     0);
    applyStimulus(2);
    rst_n = 1'b1;

    $display("[TB] idle equal inputs then full report");
    setAllEqual();
    smp_en = 1'b1;
    applyStimulus(10);
    readReport(0, 0, 0, 0);
    checkOutput("idle_first_vld", first_vld, 0);

    $display("[TB] same-cycle mismatch on chans 1 and 3");
    setChan(1, 8'h01, 8'h02);
    setChan(3, 8'h10, 8'h11);
    applyStimulus(1);
    checkOutput("multi_first_vld",  first_vld,  1);
    checkOutput("multi_first_chan", first_chan, 1);
    checkOutput("multi_first_a",    first_a,    8'h01);
    checkOutput("multi_first_b",    first_b,    8'h02);
    checkOutput("multi_any_mm",     any_mm,     1);
    setAllEqual();
    applyStimulus(1);
    checkOutput("multi_any_mm_clr", any_mm, 0);
    readReport(0, 1, 0, 1);

    $display("[TB] X detection on chan 2");
    doReset();
    setAllEqual();
    setChan(2, 8'hxx, 8'h00);
    applyStimulus(3);
    setChan(2, 8'hxx, 8'hxx);
    applyStimulus(2);
    setAllEqual();
    applyStimulus(1);
    checkOutput("x_first_b", first_b, 8'h00);
    doReset();

    $display("[TB] saturation on chan 0");
    setChan(0, 8'h01, 8'h00);
    applyStimulus(6);
    setAllEqual();
    applyStimulus(1);
    checkOutput("sat_first_chan", first_chan, 0);
    checkOutput("sat_first_a",    first_a,    8'h01);
    readReport(3, 0, 0, 0);

    $display("[TB] backpressure and accept collision on chan 1");
    rpt_req   = 1'b1;
    rpt_ready = 1'b0;
    applyStimulus(1);
    checkOutput("bp_ch0_valid", rpt_if.rpt_valid, 1);
    rpt_req   = 1'b0;
    rpt_ready = 1'b1;
    applyStimulus(1);
    checkOutput("bp_ch1_chan",  rpt_if.rpt_chan,  1);
    checkOutput("bp_ch1_cnt0",  rpt_if.rpt_count, 0);
    rpt_ready = 1'b0;
    setChan(1, 8'h77, 8'h78);
    applyStimulus(1);
    checkOutput("bp_ch1_cnt1",  rpt_if.rpt_count, 1);
    applyStimulus(1);
    checkOutput("bp_ch1_cnt2",  rpt_if.rpt_count, 2);
    setAllEqual();
    applyStimulus(1);
    checkOutput("bp_hold_cnt",  rpt_if.rpt_count, 2);
    checkOutput("bp_hold_chan", rpt_if.rpt_chan,  1);
    setChan(1, 8'h77, 8'h78);
    rpt_ready = 1'b1;
    checkOutput("bp_accept_word", rpt_if.rpt_count, 2);
    applyStimulus(1);
    setAllEqual();
    checkOutput("bp_next_chan", rpt_if.rpt_chan,  2);
    applyStimulus(2);
    checkOutput("bp_gap", rpt_if.rpt_valid, 0);
    rpt_ready = 1'b0;
    applyStimulus(1);
    readReport(0, 1, 0, 0);

    $display("[TB] reset during a report");
    setChan(0, 8'h01, 8'h02);
    setChan(3, 8'h03, 8'h04);
    applyStimulus(1);
    setAllEqual();
    rpt_req   = 1'b1;
    rpt_ready = 1'b1;
    applyStimulus(1);
    rpt_req = 1'b0;
    applyStimulus(2);
    checkOutput("mid_valid", rpt_if.rpt_valid, 1);
    checkOutput("mid_chan",  rpt_if.rpt_chan,  2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", rpt_if.rpt_valid, 0);
    checkOutput("mid_rst_first", first_vld, 0);
    applyStimulus(1);
    rpt_ready = 1'b0;
    rst_n     = 1'b1;
    applyStimulus(1);
    checkOutput("mid_idle_valid", rpt_if.rpt_valid, 0);
    readReport(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sched_cmp_probe.md
# sched_cmp_probe

Parametrised, clocked equivalence probe for the scheduling examples. It samples CHANNELS pairs of WIDTH-bit signals on the clock edge: each pair is a continuous-assignment path (`a`) and a procedural path (`b`) driven from the same source. It counts per-channel 4-state mismatches (`!==`) and captures the first mismatch. On request, it streams the per-channel counts out over a valid/ready handshake. Sampling happens only at posedge, so results do not depend on how a simulator interleaves continuous assignments and procedural processes within a time step.

## Interface
- WIDTH, 8, bits per compared signal (≥1)
- CHANNELS, 4, number of compared pairs (≥1)
- CNT_W, 8, per-channel mismatch counter width (≥2)
- IDX_W, $clog2(CHANNELS) min 1, channel index width (derived, not overridden)
- clk  input  1  sole clock, all state updates on posedge
- rst_n  input  1  reset, asynchronous and active-low
- smp_en  input  1  sample enable; pairs are compared in cycles where smp_en=1
- a  input  CHANNELS*WIDTH  continuous-path values, channel i at [i*WIDTH +: WIDTH]
- b  input  CHANNELS*WIDTH  procedural-path values, same packing
- rpt_req  input  1  request a report (level, acted on only in IDLE)
- rpt_valid  output  1  report word valid
- rpt_ready  input  1  consumer accepts report word
- rpt_chan  output  IDX_W  channel of current report word
- rpt_count  output  CNT_W  mismatch count of rpt_chan
- rpt_last  output  1  current word is channel CHANNELS-1
- first_vld  output  1  sticky: a mismatch has been captured
- first_chan  output  IDX_W  channel of first mismatch (lowest index if several in same cycle)
- first_a, first_b  output  WIDTH  captured values of that channel
- any_mm  output  1  registered OR of mismatches in the last sampled cycle

## Operation
- Compare: per channel, mm[i] = smp_en && (a_i !== b_i). The comparison is 4-state: X/Z on either side vs a known value counts as a mismatch; identical X patterns do not.
- Counters: cnt[i] increments on mm[i] and saturates at 2^CNT_W-1 (no wrap).
- First capture: when first_vld=0 and any mm[i], load the lowest i together with its a/b values and set first_vld. Further mismatches leave the capture unchanged. Only reset clears it; a report does not.
- any_mm <= |mm each cycle (0 when smp_en=0).
- Report FSM with states IDLE, SEND, DONE:
  - IDLE: rpt_valid=0. On rpt_req=1, ptr<=0 and go to SEND.
  - SEND: rpt_valid=1, rpt_chan=ptr, rpt_count=cnt[ptr], rpt_last=(ptr==CHANNELS-1). On rpt_valid&&rpt_ready, clear cnt[ptr] (clear-on-read). If last, go to DONE; otherwise ptr<=ptr+1. Without rpt_ready, all outputs hold stable, but rpt_count tracks live increments of cnt[ptr] until it is accepted.
  - DONE: rpt_valid=0 for one cycle, then IDLE. This guarantees a gap so a held rpt_req starts a fresh report at earliest 2 cycles after the last word.
- Simultaneous accept and mismatch on the same channel: the accepted word carries the old count, and cnt becomes 1 after the edge (the increment is not lost). At saturation the same rule applies: the word carries the max value and the count becomes 1.
- Channels not currently being reported keep counting during SEND.

## Timing
- Reset (rst_n=0, asynchronous): FSM=IDLE, all cnt=0, ptr=0, rpt_valid=0, rpt_chan=0, rpt_count=0, rpt_last=0, first_vld=0, first_chan=0, first_a=0, first_b=0, any_mm=0. Reset mid-report drops the report, with no partial completion. Deassertion takes effect at the next posedge.
- Compare latency: a mismatch sampled at edge N is visible in cnt, any_mm and first_* after edge N.
- Report latency: rpt_req high at edge N puts the word for channel 0 valid after edge N. With rpt_ready held at 1, one word is accepted per cycle, so a full report takes CHANNELS cycles plus 1 DONE cycle.
- No combinational path from rpt_ready to rpt_valid. rpt_count is the only output with a combinational path from a counter register.

## Test plan
- Reset then idle: WIDTH=8, CHANNELS=4, a=b=8'h5A on all channels for 10 cycles with smp_en=1, then rpt_req. Required: 4 words, all rpt_count=0, rpt_last=1 only on chan 3, first_vld=0.
- X detection: chan 2 a=8'hxx, b=8'h00 for 3 sampled cycles, then chan 2 a=b=8'hxx for 2 cycles. Required: cnt[2]=3, first_chan=2, first_b=0, any_mm=1 for exactly the 3 cycles.
- Saturation: CNT_W=2, chan 0 mismatched for 6 cycles. Required: rpt_count=3 for chan 0.
- Backpressure and collision: during SEND at chan 1, hold rpt_ready=0 for 3 cycles while chan 1 mismatches twice. Required: rpt_count goes 0→1→2 and stays stable once held. Accept it in the same cycle as another chan-1 mismatch. Required: word=2, and chan 1 reads 1 in the next report.
- Same-cycle multiple mismatch: chans 1 and 3 mismatch at once on the first mismatch edge. Required: first_chan=1, and both counters are 1.
- Reset mid-report: assert rst_n=0 asynchronously while rpt_valid=1 at chan 2. Required: rpt_valid=0 immediately, all counters=0, FSM in IDLE after release.
